// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter between N_REQ byte sources.
// Grants rotate round-robin and stay with one source until its last byte has
// gone out. Each byte is handed over as a one-cycle tx_start pulse.
// Optional build macro FRAME_TIMEOUT_EN: a source that stalls mid-frame for
// TIMEOUT_CYC cycles loses the grant and timeout_err pulses.
module uart_tx_arbiter #(
    parameter int N_REQ       = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_ready,
    output logic [N_REQ-1:0]   grant,
    output logic [7:0]         tx_data,
    output logic               tx_start,
    input  logic               tx_busy,
    output logic               frame_done,
    output logic               timeout_err
);
    localparam int IW = $clog2(N_REQ);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT_ACK, WAIT_DONE} state_t;

    state_t           state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [IW-1:0]    gidx_q, gidx_d;
    logic [IW-1:0]    last_q, last_d;
    logic             is_last_q, is_last_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_start_q, tx_start_d;
    logic             frame_done_q, frame_done_d;

    logic [IW-1:0]    cand;
    logic [IW-1:0]    pick;
    logic             pick_vld;
    logic             accept;
    logic             tmo_fire;

    // Rotating-priority pick: first valid requester after the last one served.
    always_comb begin
        cand     = '0;
        pick     = '0;
        pick_vld = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = IW'((int'(last_q) + k) % N_REQ);
            if (!pick_vld && req_valid[cand]) begin
                pick     = cand;
                pick_vld = 1'b1;
            end
        end
    end

    // A byte is consumed only from the owner, in LOAD, with the UART idle.
    assign accept    = (state_q == LOAD) && req_valid[gidx_q] && !tx_busy;
    assign req_ready = accept ? grant_q : '0;

`ifdef FRAME_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] tmo_q, tmo_d;
    logic          tmo_err_q;

    // Fire on the edge where the stall count would reach TIMEOUT_CYC.
    assign tmo_fire = (state_q == LOAD) && !req_valid[gidx_q] &&
                      (tmo_q == CW'(TIMEOUT_CYC - 1));

    // Stall counter: counts owner-idle cycles in LOAD, restarts on any accept.
    always_comb begin
        tmo_d = tmo_q;
        if (state_q != LOAD || accept || tmo_fire)
            tmo_d = '0;
        else if (!req_valid[gidx_q])
            tmo_d = tmo_q + CW'(1);
    end

    // Stall counter and timeout pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q     <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            tmo_q     <= tmo_d;
            tmo_err_q <= tmo_fire;
        end
    end

    assign timeout_err = tmo_err_q;
`else
    assign tmo_fire    = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // Next-state and next-output logic of the grant/transmit FSM.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        gidx_d       = gidx_q;
        last_d       = last_q;
        is_last_d    = is_last_q;
        tx_data_d    = tx_data_q;
        tx_start_d   = 1'b0;
        frame_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    grant_d = N_REQ'(1) << pick;
                    gidx_d  = pick;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (accept) begin
                    tx_data_d  = req_data[{gidx_q, 3'b000} +: 8];
                    tx_start_d = 1'b1;
                    is_last_d  = req_last[gidx_q];
                    state_d    = WAIT_ACK;
                end else if (tmo_fire) begin
                    last_d  = gidx_q;
                    grant_d = '0;
                    state_d = IDLE;
                end
            end
            WAIT_ACK: begin
                if (tx_busy) state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    if (is_last_q) begin
                        frame_done_d = 1'b1;
                        last_d       = gidx_q;
                        grant_d      = '0;
                        state_d      = IDLE;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state and registered outputs; reset aborts any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            gidx_q       <= '0;
            last_q       <= IW'(N_REQ - 1);
            is_last_q    <= 1'b0;
            tx_data_q    <= '0;
            tx_start_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            gidx_q       <= gidx_d;
            last_q       <= last_d;
            is_last_q    <= is_last_d;
            tx_data_q    <= tx_data_d;
            tx_start_q   <= tx_start_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign grant      = grant_q;
    assign tx_data    = tx_data_q;
    assign tx_start   = tx_start_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: per-source byte FIFOs drive the requests, a
// simple UART model answers tx_start with a 10-cycle busy window, and a
// monitor logs every tx_start byte for scoreboard comparison in each test.
module tb_uart_tx_arbiter;
    localparam int N    = 4;
    localparam int BUSY = 10;

    typedef struct packed {
        logic [N-1:0] gnt;
        logic [7:0]   data;
        logic [31:0]  cyc;
    } ev_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]   req_last = '0;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   grant;
    logic [7:0]     tx_data;
    logic           tx_start;
    logic           tx_busy = 1'b0;
    logic           frame_done;
    logic           timeout_err;

    uart_tx_arbiter #(.N_REQ(N), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready), .grant(grant),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
        .frame_done(frame_done), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int fd_cnt = 0;
    int to_cnt = 0;
    int ohv    = 0;
    logic [31:0] cyc = 0;

    logic [8:0] src_mem [N][16];
    int         src_head [N];
    int         src_tail [N];
    logic [N-1:0] rdy_s = '0;
    int         busy_cnt = 0;
    bit         start_pend = 0;

    ev_t exp_q[$];
    ev_t obs_q[$];

    function automatic ev_t mk(input logic [N-1:0] g, input logic [7:0] d);
        ev_t e;
        e.gnt  = g;
        e.data = d;
        e.cyc  = '0;
        return e;
    endfunction

    task automatic src_push(input int i, input logic l, input logic [7:0] d);
        src_mem[i][src_tail[i] % 16] = {l, d};
        src_tail[i]++;
    endtask

    task automatic src_flush();
        for (int i = 0; i < N; i++) src_head[i] = src_tail[i];
    endtask

    task automatic wait_fd(input int target, input int budget, output bit ok);
        ok = 0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk); #3;
            if (fd_cnt >= target) begin
                ok = 1;
                break;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            src_head[i] = 0;
            src_tail[i] = 0;
        end
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Requesters and UART model: everything changes on the falling edge.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            req_valid  = '0;
            req_last   = '0;
            tx_busy    = 1'b0;
            busy_cnt   = 0;
            start_pend = 0;
            rdy_s      = '0;
        end else begin
            if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) tx_busy = 1'b0;
            end
            if (start_pend) begin
                tx_busy    = 1'b1;
                busy_cnt   = BUSY;
                start_pend = 0;
            end
            if (tx_start) start_pend = 1;
            for (int i = 0; i < N; i++)
                if (rdy_s[i]) src_head[i]++;
            for (int i = 0; i < N; i++) begin
                if (src_head[i] != src_tail[i]) begin
                    req_valid[i]        = 1'b1;
                    req_data[8*i +: 8]  = src_mem[i][src_head[i] % 16][7:0];
                    req_last[i]         = src_mem[i][src_head[i] % 16][8];
                end else begin
                    req_valid[i]        = 1'b0;
                    req_data[8*i +: 8]  = '0;
                    req_last[i]         = 1'b0;
                end
            end
            #1 rdy_s = req_ready;
        end
    end

    // Monitor: log issued bytes and count pulses / ready violations.
    initial forever begin
        ev_t e;
        @(negedge clk); #2;
        if (rst_n) begin
            if (tx_start) begin
                e.gnt  = grant;
                e.data = tx_data;
                e.cyc  = cyc;
                obs_q.push_back(e);
            end
            if (frame_done) fd_cnt++;
            if (timeout_err) to_cnt++;
            if ($countones(req_ready) > 1 || (req_ready & ~grant) != '0) ohv++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic apply_reset();
        @(negedge clk); #3;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        src_flush();
        exp_q.delete();
        obs_q.delete();
        @(negedge clk); #4;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        checks++; if (grant !== '0) $display("FAIL reset_grant: got %b want 0", grant); else passes++;
        checks++; if (tx_start !== 1'b0) $display("FAIL reset_tx_start: got %b want 0", tx_start); else passes++;
        checks++; if (req_ready !== '0) $display("FAIL reset_req_ready: got %b want 0", req_ready); else passes++;
        checks++; if (tx_data !== 8'h00) $display("FAIL reset_tx_data: got %h want 00", tx_data); else passes++;
        checks++; if (frame_done !== 1'b0) $display("FAIL reset_frame_done: got %b want 0", frame_done); else passes++;
        checks++; if (timeout_err !== 1'b0) $display("FAIL reset_timeout_err: got %b want 0", timeout_err); else passes++;
        @(negedge clk); #4;
        rst_n = 1'b1;
    endtask

    task automatic test_single_frame();
        ev_t e, o;
        int t0, fd0;
        bit ok;
        @(posedge clk); #1;
        t0  = cyc;
        fd0 = fd_cnt;
        src_push(2, 1'b0, 8'h41);
        src_push(2, 1'b1, 8'h42);
        exp_q.push_back(mk(4'b0100, 8'h41));
        exp_q.push_back(mk(4'b0100, 8'h42));
        wait_fd(fd0 + 1, 200, ok);
        checks++; if (!ok) $display("FAIL single_frame_done: no frame_done within 200 cycles"); else passes++;
        repeat (4) @(negedge clk); #3;
        checks++; if (fd_cnt - fd0 !== 1) $display("FAIL single_frame_done_count: got %0d want 1", fd_cnt - fd0); else passes++;
        checks++; if (grant !== '0) $display("FAIL single_grant_release: got %b want 0", grant); else passes++;
        checks++; if (obs_q.size() !== 2) $display("FAIL single_byte_count: got %0d want 2", obs_q.size()); else passes++;
        if (obs_q.size() > 0) begin
            checks++;
            if (obs_q[0].cyc - t0 !== 2) $display("FAIL single_latency: got %0d want 2", obs_q[0].cyc - t0);
            else passes++;
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) $display("FAIL single_sb: missing byte, want %h grant %b", e.data, e.gnt);
            else begin
                o = obs_q.pop_front();
                if (o.data !== e.data || o.gnt !== e.gnt)
                    $display("FAIL single_sb: got %h grant %b want %h grant %b", o.data, o.gnt, e.data, e.gnt);
                else passes++;
            end
        end
    endtask

    task automatic test_contention();
        ev_t e, o;
        int fd0;
        bit ok;
        apply_reset();
        @(posedge clk); #1;
        fd0 = fd_cnt;
        src_push(0, 1'b1, 8'hA0);
        src_push(1, 1'b1, 8'hA1);
        src_push(3, 1'b1, 8'hA3);
        exp_q.push_back(mk(4'b0001, 8'hA0));
        exp_q.push_back(mk(4'b0010, 8'hA1));
        exp_q.push_back(mk(4'b1000, 8'hA3));
        wait_fd(fd0 + 3, 400, ok);
        checks++; if (!ok) $display("FAIL contention_round1: got %0d frames want 3", fd_cnt - fd0); else passes++;
        // 3 finished last, so rotation starts at 0 for the re-requests.
        @(posedge clk); #1;
        src_push(3, 1'b1, 8'hB3);
        src_push(0, 1'b1, 8'hB0);
        exp_q.push_back(mk(4'b0001, 8'hB0));
        exp_q.push_back(mk(4'b1000, 8'hB3));
        wait_fd(fd0 + 5, 400, ok);
        checks++; if (!ok) $display("FAIL contention_round2: got %0d frames want 5", fd_cnt - fd0); else passes++;
        repeat (2) @(negedge clk); #3;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) $display("FAIL contention_sb: missing byte, want %h grant %b", e.data, e.gnt);
            else begin
                o = obs_q.pop_front();
                if (o.data !== e.data || o.gnt !== e.gnt)
                    $display("FAIL contention_sb: got %h grant %b want %h grant %b", o.data, o.gnt, e.data, e.gnt);
                else passes++;
            end
        end
    endtask

    task automatic test_atomicity();
        ev_t e, o;
        int fd0, viol;
        bit ok, seen;
        @(posedge clk); #1;
        fd0  = fd_cnt;
        viol = 0;
        seen = 0;
        src_push(1, 1'b0, 8'h11);
        src_push(1, 1'b0, 8'h12);
        src_push(1, 1'b1, 8'h13);
        exp_q.push_back(mk(4'b0010, 8'h11));
        exp_q.push_back(mk(4'b0010, 8'h12));
        exp_q.push_back(mk(4'b0010, 8'h13));
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk); #3;
            if (grant == 4'b0010) seen = 1;
        end
        checks++; if (!seen) $display("FAIL atomic_grant1: got %b want 0010", grant); else passes++;
        src_push(0, 1'b1, 8'h05);
        exp_q.push_back(mk(4'b0001, 8'h05));
        ok = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk); #3;
            if (req_ready[0]) viol++;
            if (fd_cnt >= fd0 + 1) begin
                ok = 1;
                break;
            end
        end
        checks++; if (!ok) $display("FAIL atomic_frame1_done: no frame_done within 300 cycles"); else passes++;
        checks++; if (viol !== 0) $display("FAIL atomic_ready0: got %0d cycles with ready want 0", viol); else passes++;
        wait_fd(fd0 + 2, 200, ok);
        checks++; if (!ok) $display("FAIL atomic_frame0_done: got %0d frames want 2", fd_cnt - fd0); else passes++;
        repeat (2) @(negedge clk); #3;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) $display("FAIL atomic_sb: missing byte, want %h grant %b", e.data, e.gnt);
            else begin
                o = obs_q.pop_front();
                if (o.data !== e.data || o.gnt !== e.gnt)
                    $display("FAIL atomic_sb: got %h grant %b want %h grant %b", o.data, o.gnt, e.data, e.gnt);
                else passes++;
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        ev_t e, o;
        int fd0;
        bit ok, seen;
        @(posedge clk); #1;
        seen = 0;
        src_push(3, 1'b0, 8'h31);
        src_push(3, 1'b1, 8'h32);
        exp_q.push_back(mk(4'b1000, 8'h31));
        for (int c = 0; c < 30 && !seen; c++) begin
            @(negedge clk); #3;
            if (tx_busy) seen = 1;
        end
        checks++; if (!seen || grant !== 4'b1000) $display("FAIL midrst_setup: busy %b grant %b want 1 1000", tx_busy, grant); else passes++;
        rst_n = 1'b0;
        #1;
        checks++; if (grant !== '0) $display("FAIL midrst_grant: got %b want 0", grant); else passes++;
        checks++; if (tx_data !== 8'h00) $display("FAIL midrst_tx_data: got %h want 00", tx_data); else passes++;
        checks++; if (tx_start !== 1'b0 || frame_done !== 1'b0) $display("FAIL midrst_pulses: got %b%b want 00", tx_start, frame_done); else passes++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) $display("FAIL midrst_sb: missing byte, want %h grant %b", e.data, e.gnt);
            else begin
                o = obs_q.pop_front();
                if (o.data !== e.data || o.gnt !== e.gnt)
                    $display("FAIL midrst_sb: got %h grant %b want %h grant %b", o.data, o.gnt, e.data, e.gnt);
                else passes++;
            end
        end
        repeat (3) @(posedge clk);
        src_flush();
        obs_q.delete();
        @(negedge clk); #4;
        rst_n = 1'b1;
        @(posedge clk); #1;
        fd0 = fd_cnt;
        src_push(2, 1'b1, 8'h52);
        src_push(0, 1'b1, 8'h50);
        exp_q.push_back(mk(4'b0001, 8'h50));
        exp_q.push_back(mk(4'b0100, 8'h52));
        wait_fd(fd0 + 2, 300, ok);
        checks++; if (!ok) $display("FAIL midrst_rearb: got %0d frames want 2", fd_cnt - fd0); else passes++;
        repeat (2) @(negedge clk); #3;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) $display("FAIL midrst_sb2: missing byte, want %h grant %b", e.data, e.gnt);
            else begin
                o = obs_q.pop_front();
                if (o.data !== e.data || o.gnt !== e.gnt)
                    $display("FAIL midrst_sb2: got %h grant %b want %h grant %b", o.data, o.gnt, e.data, e.gnt);
                else passes++;
            end
        end
    endtask

    task automatic test_stall();
        ev_t e, o;
        int fd0, to0;
        logic [31:0] c_fall, c_to;
        bit ok, seen;
        @(posedge clk); #1;
        fd0 = fd_cnt;
        to0 = to_cnt;
        seen = 0;
        src_push(2, 1'b0, 8'h61);
        exp_q.push_back(mk(4'b0100, 8'h61));
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk); #3;
            if (grant == 4'b0100) seen = 1;
        end
        checks++; if (!seen) $display("FAIL stall_grant2: got %b want 0100", grant); else passes++;
        src_push(3, 1'b1, 8'h71);
`ifdef FRAME_TIMEOUT_EN
        exp_q.push_back(mk(4'b1000, 8'h71));
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk); #3;
            if (tx_busy) seen = 1;
        end
        c_fall = '0;
        for (int c = 0; c < 30 && seen; c++) begin
            @(negedge clk); #3;
            if (!tx_busy) begin
                c_fall = cyc;
                break;
            end
        end
        c_to = '0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk); #3;
            if (timeout_err) begin
                c_to = cyc;
                break;
            end
        end
        checks++; if (c_to - c_fall !== 17) $display("FAIL stall_timeout_time: got %0d want 17", c_to - c_fall); else passes++;
        checks++; if (grant !== '0) $display("FAIL stall_release: got %b want 0", grant); else passes++;
        wait_fd(fd0 + 1, 200, ok);
        checks++; if (!ok) $display("FAIL stall_next_frame: no frame_done within 200 cycles"); else passes++;
        repeat (2) @(negedge clk); #3;
        checks++; if (to_cnt - to0 !== 1) $display("FAIL stall_timeout_count: got %0d want 1", to_cnt - to0); else passes++;
        checks++; if (fd_cnt - fd0 !== 1) $display("FAIL stall_frame_count: got %0d want 1", fd_cnt - fd0); else passes++;
`else
        c_fall = '0;
        c_to   = '0;
        ok     = 0;
        repeat (60) @(negedge clk);
        #3;
        checks++; if (grant !== 4'b0100) $display("FAIL stall_hold_grant: got %b want 0100", grant); else passes++;
        checks++; if (req_ready !== '0) $display("FAIL stall_ready: got %b want 0", req_ready); else passes++;
        checks++; if (to_cnt - to0 !== 0) $display("FAIL stall_no_timeout: got %0d want 0", to_cnt - to0); else passes++;
        checks++; if (fd_cnt - fd0 !== 0) $display("FAIL stall_no_frame: got %0d want 0", fd_cnt - fd0); else passes++;
`endif
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) $display("FAIL stall_sb: missing byte, want %h grant %b", e.data, e.gnt);
            else begin
                o = obs_q.pop_front();
                if (o.data !== e.data || o.gnt !== e.gnt)
                    $display("FAIL stall_sb: got %h grant %b want %h grant %b", o.data, o.gnt, e.data, e.gnt);
                else passes++;
            end
        end
        checks++; if (obs_q.size() !== 0) $display("FAIL stall_extra_bytes: got %0d want 0", obs_q.size()); else passes++;
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_contention();
        test_atomicity();
        test_reset_mid_frame();
        test_stall();
        checks++; if (ohv !== 0) $display("FAIL ready_onehot: got %0d bad cycles want 0", ohv); else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
